// File: rtl/args_delay_prog.sv
// args_delay_prog: runtime-programmable delay line (1..MAX_DELAY cycles) for a data bus plus valid.
// Optional clock enable port ce via `define ARGS_DELAY_PROG_CE_EN.
module args_delay_prog #(
  parameter int    WIDTH     = 8,
  parameter int    MAX_DELAY = 512,
  parameter int    DEF_DELAY = 16,
  parameter string TYPE      = "BRAM",
  localparam int   DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ARGS_DELAY_PROG_CE_EN
  input  logic             ce,
`endif
  input  logic             cfg_load,
  input  logic [DW-1:0]    cfg_delay,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DW-1:0]    cur_delay,
  output logic             priming,
  output logic             cfg_err
);
  localparam int AW    = $clog2(MAX_DELAY);
  localparam int DEPTH = 1 << AW;
  logic            adv, acc;
  logic [AW-1:0]   wptr_q, wptr_d, raddr;
  logic [DW-1:0]   cur_q, cur_d, cnt_q, cnt_d;
  logic [WIDTH:0]  byp_q, byp_d, rd_q, sel;
  logic            err_q, err_d;
  (* ram_style = TYPE *) logic [WIDTH:0] mem [DEPTH];
`ifdef ARGS_DELAY_PROG_CE_EN
  assign adv = ce;
`else
  assign adv = 1'b1;
`endif
  always_comb begin
    acc    = cfg_load && cfg_delay != '0 && cfg_delay <= DW'(MAX_DELAY);
    err_d  = cfg_load && !acc;
    cur_d  = acc ? cfg_delay : cur_q;
    cnt_d  = acc ? cfg_delay : (adv && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    wptr_d = adv ? wptr_q + 1'b1 : wptr_q;
    byp_d  = adv ? {in_valid, in_data} : byp_q;
    raddr  = wptr_q - AW'(cur_q - 1'b1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      cur_q  <= DW'(DEF_DELAY);
      cnt_q  <= DW'(DEF_DELAY);
      byp_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      byp_q  <= byp_d;
      err_q  <= err_d;
    end
  end
  // Unreset storage with registered read so it maps onto block/distributed RAM
  always_ff @(posedge clk) begin
    if (adv) begin
      mem[wptr_q] <= {in_valid, in_data};
      rd_q        <= mem[raddr];
    end
  end
  // D=1 reads from the bypass register; delay only changes under priming, so the mux never glitches out
  assign sel       = (cur_q == DW'(1)) ? byp_q : rd_q;
  assign priming   = cnt_q != '0;
  assign out_valid = !priming && sel[WIDTH];
  assign out_data  = priming ? '0 : sel[WIDTH-1:0];
  assign cur_delay = cur_q;
  assign cfg_err   = err_q;
endmodule
